ebi_master: RTL and testbench
=============================

EBI_MASTER -- requirements
Module: ebi_master

Interface
REQ-001 Parameter SETUP_CYC, default 1: cycles with cs_n low before strobe; 0 is treated as 1.
REQ-002 Parameter STROBE_CYC, default 3: cycles with oe_n or we_n asserted; 0 is treated as 1.
REQ-003 Parameter HOLD_CYC, default 1: cycles with cs_n low after strobe; 0 is treated as 1.
REQ-004 Parameter TURN_CYC, default 1: bus-idle cycles after a read before returning to idle; 0 is treated as 1.
REQ-005 clk  input  1  single clock; all logic rising-edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 req_valid  input  1  request present.
REQ-008 req_ready  output  1  master can accept a request.
REQ-009 req_wr  input  1  1 = write, 0 = read.
REQ-010 req_addr  input  24  bus address.
REQ-011 req_wdata  input  32  write data.
REQ-012 req_be  input  4  byte enables; bit i maps to we_n[i].
REQ-013 done  output  1  one-cycle completion pulse.
REQ-014 rdata  output  32  last read data.
REQ-015 cs_n, oe_n, rd_wr  output  1 each  EBI chip select, output enable, read(1)/write(0).
REQ-016 we_n  output  4  EBI byte write strobes, active low.
REQ-017 ebi_addr  output  24  EBI address.
REQ-018 ebi_data_o / ebi_data_oe / ebi_data_i  output 32 / output 1 / input 32  split tri-state data bus; the pad is driven only while ebi_data_oe = 1.

Function
REQ-019 All EBI outputs, done and rdata shall come straight from flops.
REQ-020 FSM states: IDLE, SETUP, STROBE, HOLD, TURN; an 8-bit down-counter shall time each state.
REQ-021 req_ready shall be 1 only in IDLE; a request is accepted on a clk edge where req_valid and req_ready are both 1.
REQ-022 On acceptance, the block shall latch addr, wdata, be and wr; later input changes shall not affect the transfer in flight.
REQ-023 IDLE outputs: cs_n=1, oe_n=1, we_n=4'hF, rd_wr=1, ebi_data_oe=0; ebi_addr shall keep its last value.
REQ-024 SETUP (SETUP_CYC cycles): cs_n=0, rd_wr=~wr, ebi_addr=latched addr, ebi_data_oe=wr, ebi_data_o=latched wdata, strobes inactive.
REQ-025 STROBE (STROBE_CYC cycles): a read shall drive oe_n=0; a write shall drive we_n=~be.
REQ-026 Read sampling: ebi_data_i shall be sampled into rdata at the clk edge that ends the last STROBE cycle.
REQ-027 HOLD (HOLD_CYC cycles): strobes inactive; cs_n, addr, rd_wr and write data unchanged.
REQ-028 After HOLD: a write shall go to IDLE; a read shall go to TURN.
REQ-029 TURN (TURN_CYC cycles): cs_n=1, oe_n=1, ebi_data_oe=0, rd_wr=1; then go to IDLE.
REQ-030 done shall be 1 for exactly the first IDLE cycle after a transfer completes.
REQ-031 rdata shall hold its value until the next read completes; writes shall not alter it.
REQ-032 Write latency: acceptance edge to done = SETUP_CYC+STROBE_CYC+HOLD_CYC+1 cycles; read latency adds TURN_CYC.
REQ-033 Back-to-back: with req_valid held high, the next request shall be accepted in the done cycle, so cs_n is high for exactly 1 cycle between writes.
REQ-034 A write with req_be=4'h0 shall produce no bus activity (cs_n stays 1) and shall pulse done on the 2nd cycle after acceptance.
REQ-035 ebi_data_oe shall never be 1 while oe_n=0.

Reset
REQ-036 When rst_n=0, the block shall immediately (asynchronously) enter IDLE with the REQ-023 outputs, ebi_addr=0, ebi_data_o=0, rdata=0, done=0 and counter=0, including mid-transfer.
REQ-037 The first request shall be accepted on the first clk edge after rst_n deasserts.

Verification
REQ-038 Write, defaults: addr=24'h000123, wdata=32'hA5A5_1234, be=4'hF -> cs_n low for 5 cycles, we_n=4'h0 for 3 cycles, data driven all 5 cycles, done at acceptance+6.
REQ-039 Read, defaults, slave drives 32'hDEAD_BEEF -> oe_n low for 3 cycles, ebi_data_oe=0 throughout, rdata=32'hDEAD_BEEF with done at acceptance+7.
REQ-040 Byte write be=4'b0101 -> we_n=4'b1010 during STROBE; be=4'h0 -> no cs_n activity and done at acceptance+2.
REQ-041 Two writes with req_valid held high -> exactly 1 cs_n-high cycle between them; req_ready low throughout each transfer.
REQ-042 rst_n pulsed low during the 2nd STROBE cycle -> all strobes inactive and ebi_data_oe=0 within the same cycle, rdata=0, no done pulse.
REQ-043 SETUP_CYC=0, STROBE_CYC=5, HOLD_CYC=2 read -> 1/5/2/1 cycle phases and done at acceptance+10.

Source files
------------

// File: rtl/ebi_master_if.sv
// Request/completion handshake plus the external bus pins of the EBI master.
// The master modport is the controller's view; slave is the request source and external device.
interface ebi_master_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [23:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        done;
    logic [31:0] rdata;
    logic        cs_n;
    logic        oe_n;
    logic        rd_wr;
    logic [3:0]  we_n;
    logic [23:0] ebi_addr;
    logic [31:0] ebi_data_o;
    logic        ebi_data_oe;
    logic [31:0] ebi_data_i;

    modport master (
        input  req_valid, req_wr, req_addr, req_wdata, req_be, ebi_data_i,
        output req_ready, done, rdata, cs_n, oe_n, rd_wr, we_n,
               ebi_addr, ebi_data_o, ebi_data_oe
    );

    modport slave (
        output req_valid, req_wr, req_addr, req_wdata, req_be, ebi_data_i,
        input  req_ready, done, rdata, cs_n, oe_n, rd_wr, we_n,
               ebi_addr, ebi_data_o, ebi_data_oe
    );
endinterface

// File: rtl/ebi_master.sv
// Asynchronous external bus master: one request at a time sequenced through
// setup / strobe / hold / turnaround phases; every pin is driven from a flop.
module ebi_master #(
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 3,
    parameter int HOLD_CYC   = 1,
    parameter int TURN_CYC   = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    ebi_master_if.master bus
);
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SETUP  = 3'd1;
    localparam logic [2:0] ST_STROBE = 3'd2;
    localparam logic [2:0] ST_HOLD   = 3'd3;
    localparam logic [2:0] ST_TURN   = 3'd4;

    // Counter reload values: a phase of N cycles loads N-1; zero-length phases last one cycle.
    localparam logic [7:0] SETUP_LD  = (SETUP_CYC  > 1) ? 8'(SETUP_CYC  - 1) : 8'd0;
    localparam logic [7:0] STROBE_LD = (STROBE_CYC > 1) ? 8'(STROBE_CYC - 1) : 8'd0;
    localparam logic [7:0] HOLD_LD   = (HOLD_CYC   > 1) ? 8'(HOLD_CYC   - 1) : 8'd0;
    localparam logic [7:0] TURN_LD   = (TURN_CYC   > 1) ? 8'(TURN_CYC   - 1) : 8'd0;

    logic [2:0]  r_state;
    logic [7:0]  r_cnt;
    logic        r_wr;
    logic [3:0]  r_be;
    logic        r_cs_n;
    logic        r_oe_n;
    logic        r_rd_wr;
    logic [3:0]  r_we_n;
    logic [23:0] r_addr;
    logic [31:0] r_data_o;
    logic        r_data_oe;
    logic [31:0] r_rdata;
    logic        r_done;
    logic        w_cnt_zero;

    assign w_cnt_zero = (r_cnt == 8'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= 8'd0;
            r_wr      <= 1'b0;
            r_be      <= 4'h0;
            r_cs_n    <= 1'b1;
            r_oe_n    <= 1'b1;
            r_rd_wr   <= 1'b1;
            r_we_n    <= 4'hF;
            r_addr    <= 24'd0;
            r_data_o  <= 32'd0;
            r_data_oe <= 1'b0;
            r_rdata   <= 32'd0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        r_wr <= bus.req_wr;
                        r_be <= bus.req_be;
                        // An all-zero byte mask completes through a single quiet TURN cycle.
                        if (bus.req_wr && (bus.req_be == 4'h0)) begin
                            r_state <= ST_TURN;
                            r_cnt   <= 8'd0;
                        end else begin
                            r_state   <= ST_SETUP;
                            r_cnt     <= SETUP_LD;
                            r_cs_n    <= 1'b0;
                            r_rd_wr   <= ~bus.req_wr;
                            r_addr    <= bus.req_addr;
                            r_data_o  <= bus.req_wdata;
                            r_data_oe <= bus.req_wr;
                        end
                    end
                end
                ST_SETUP: begin
                    if (w_cnt_zero) begin
                        r_state <= ST_STROBE;
                        r_cnt   <= STROBE_LD;
                        if (r_wr) begin
                            r_we_n <= ~r_be;
                        end else begin
                            r_oe_n <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                ST_STROBE: begin
                    if (w_cnt_zero) begin
                        r_state <= ST_HOLD;
                        r_cnt   <= HOLD_LD;
                        r_we_n  <= 4'hF;
                        r_oe_n  <= 1'b1;
                        if (!r_wr) begin
                            r_rdata <= bus.ebi_data_i;
                        end
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                ST_HOLD: begin
                    if (w_cnt_zero) begin
                        r_cs_n    <= 1'b1;
                        r_rd_wr   <= 1'b1;
                        r_data_oe <= 1'b0;
                        if (r_wr) begin
                            r_state <= ST_IDLE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_TURN;
                            r_cnt   <= TURN_LD;
                        end
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                ST_TURN: begin
                    if (w_cnt_zero) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= 8'd0;
                end
            endcase
        end
    end

    assign bus.req_ready   = (r_state == ST_IDLE);
    assign bus.done        = r_done;
    assign bus.rdata       = r_rdata;
    assign bus.cs_n        = r_cs_n;
    assign bus.oe_n        = r_oe_n;
    assign bus.rd_wr       = r_rd_wr;
    assign bus.we_n        = r_we_n;
    assign bus.ebi_addr    = r_addr;
    assign bus.ebi_data_o  = r_data_o;
    assign bus.ebi_data_oe = r_data_oe;
endmodule

// File: tb/tb_ebi_master.sv
// Scoreboard bench for ebi_master: default timing (dut0) and a 0/5/2 timing variant (dut1).
// Stimulus queues hand-computed expectations; a negedge monitor measures each bus cycle.
module tb_ebi_master;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          lat;
        int          cs;
        int          pre;
        int          strb;
        logic [3:0]  we;
        int          doe;
        int          gap;
        logic [23:0] addr;
        logic [31:0] data;
        logic [31:0] rdata;
    } exp_t;

    exp_t exp_q[2][$];
    int   n_checks = 0;
    int   n_errs   = 0;

    logic        d_valid[2];
    logic        d_wr[2];
    logic [23:0] d_addr[2];
    logic [31:0] d_wdata[2];
    logic [3:0]  d_be[2];
    logic [31:0] slave_val[2];

    logic        m_ready[2], m_done[2], m_cs[2], m_oe[2], m_rdwr[2], m_doe[2];
    logic [3:0]  m_we[2];
    logic [23:0] m_addr[2];
    logic [31:0] m_data[2], m_rdata[2];

    ebi_master_if bus0();
    ebi_master_if bus1();

    ebi_master u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.master));
    ebi_master #(.SETUP_CYC(0), .STROBE_CYC(5), .HOLD_CYC(2), .TURN_CYC(1))
        u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.master));

    assign bus0.req_valid  = d_valid[0];
    assign bus0.req_wr     = d_wr[0];
    assign bus0.req_addr   = d_addr[0];
    assign bus0.req_wdata  = d_wdata[0];
    assign bus0.req_be     = d_be[0];
    assign bus0.ebi_data_i = bus0.oe_n ? 32'h0 : slave_val[0];
    assign bus1.req_valid  = d_valid[1];
    assign bus1.req_wr     = d_wr[1];
    assign bus1.req_addr   = d_addr[1];
    assign bus1.req_wdata  = d_wdata[1];
    assign bus1.req_be     = d_be[1];
    assign bus1.ebi_data_i = bus1.oe_n ? 32'h0 : slave_val[1];

    assign m_ready[0] = bus0.req_ready;   assign m_ready[1] = bus1.req_ready;
    assign m_done[0]  = bus0.done;        assign m_done[1]  = bus1.done;
    assign m_cs[0]    = bus0.cs_n;        assign m_cs[1]    = bus1.cs_n;
    assign m_oe[0]    = bus0.oe_n;        assign m_oe[1]    = bus1.oe_n;
    assign m_rdwr[0]  = bus0.rd_wr;       assign m_rdwr[1]  = bus1.rd_wr;
    assign m_doe[0]   = bus0.ebi_data_oe; assign m_doe[1]   = bus1.ebi_data_oe;
    assign m_we[0]    = bus0.we_n;        assign m_we[1]    = bus1.we_n;
    assign m_addr[0]  = bus0.ebi_addr;    assign m_addr[1]  = bus1.ebi_addr;
    assign m_data[0]  = bus0.ebi_data_o;  assign m_data[1]  = bus1.ebi_data_o;
    assign m_rdata[0] = bus0.rdata;       assign m_rdata[1] = bus1.rdata;

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s dut%0d: got %h expected %h", nm, k, act, exp);
        end
    endtask

    // Per-transaction measurements, restarted at each acceptance.
    int          n = 0;
    logic        in_fl[2]   = '{1'b0, 1'b0};
    logic        prev_done[2] = '{1'b0, 1'b0};
    int          t_start[2], t_cs[2], t_pre[2], t_strb[2], t_doe[2];
    int          t_rdy[2], t_viol[2], t_gap[2], cs_run[2];
    logic [3:0]  t_we[2];
    logic [23:0] t_addr[2];
    logic [31:0] t_data[2];

    always @(negedge clk) begin
        n++;
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                chk("rst_ctrl", k, {23'd0, m_cs[k], m_oe[k], m_we[k], m_rdwr[k], m_doe[k], m_done[k]}, 32'h1FC);
                chk("rst_rdata", k, m_rdata[k], 32'h0);
                chk("rst_addr", k, {8'd0, m_addr[k]}, 32'h0);
                chk("rst_data_o", k, m_data[k], 32'h0);
                in_fl[k]     = 1'b0;
                prev_done[k] = 1'b0;
                cs_run[k]    = 0;
            end else begin
                if (prev_done[k]) chk("done_width", k, {31'd0, m_done[k]}, 32'h0);
                if (in_fl[k]) begin
                    if (m_done[k]) begin
                        in_fl[k] = 1'b0;
                        if (exp_q[k].size() == 0) begin
                            n_checks++; n_errs++;
                            $display("FAIL unexpected_done dut%0d: got done with no pending request expected none", k);
                        end else begin
                            exp_t e;
                            e = exp_q[k].pop_front();
                            $display("txn dut%0d lat=%0d cs_low=%0d strobe=%0d rdata=%h", k, n - t_start[k], t_cs[k], t_strb[k], m_rdata[k]);
                            chk("latency", k, n - t_start[k], e.lat);
                            chk("cs_low_cycles", k, t_cs[k], e.cs);
                            chk("setup_cycles", k, t_pre[k], e.pre);
                            chk("strobe_cycles", k, t_strb[k], e.strb);
                            chk("we_n_strobe", k, {28'd0, t_we[k]}, {28'd0, e.we});
                            chk("data_oe_cycles", k, t_doe[k], e.doe);
                            chk("ready_in_flight", k, t_rdy[k], 0);
                            chk("oe_conflict", k, t_viol[k], 0);
                            chk("rdata", k, m_rdata[k], e.rdata);
                            if (e.cs > 0)  chk("ebi_addr", k, {8'd0, t_addr[k]}, {8'd0, e.addr});
                            if (e.doe > 0) chk("ebi_data_o", k, t_data[k], e.data);
                            if (e.gap >= 0) chk("cs_gap", k, t_gap[k], e.gap);
                        end
                    end else begin
                        if (!m_cs[k]) begin
                            if (t_cs[k] == 0) t_gap[k] = cs_run[k];
                            t_cs[k]++;
                            t_addr[k] = m_addr[k];
                            if (t_strb[k] == 0 && m_oe[k] && m_we[k] == 4'hF) t_pre[k]++;
                        end
                        if (!m_oe[k] || m_we[k] != 4'hF) begin
                            t_strb[k]++;
                            t_we[k] = t_we[k] & m_we[k];
                        end
                        if (m_doe[k]) begin
                            t_doe[k]++;
                            t_data[k] = m_data[k];
                        end
                        if (m_ready[k]) t_rdy[k]++;
                        if (m_doe[k] && !m_oe[k]) t_viol[k]++;
                        if (n - t_start[k] > 100) begin
                            n_checks++; n_errs++;
                            $display("FAIL timeout dut%0d: no done after %0d cycles required within 100", k, n - t_start[k]);
                            in_fl[k] = 1'b0;
                            if (exp_q[k].size() != 0) void'(exp_q[k].pop_front());
                        end
                    end
                end else if (m_done[k]) begin
                    n_checks++; n_errs++;
                    $display("FAIL unexpected_done dut%0d: got done while idle expected none", k);
                end
                if (m_valid_ready(k)) begin
                    in_fl[k]   = 1'b1;
                    t_start[k] = n;
                    t_cs[k] = 0; t_pre[k] = 0; t_strb[k] = 0; t_doe[k] = 0;
                    t_rdy[k] = 0; t_viol[k] = 0; t_gap[k] = -1;
                    t_we[k] = 4'hF; t_addr[k] = 24'd0; t_data[k] = 32'd0;
                end
                cs_run[k]    = m_cs[k] ? cs_run[k] + 1 : 0;
                prev_done[k] = m_done[k];
            end
        end
    end

    function automatic logic m_valid_ready(input int k);
        return d_valid[k] && m_ready[k];
    endfunction

    function automatic exp_t mk(input int lat, input int cs, input int pre, input int strb,
                                input logic [3:0] we, input int doe, input int gap,
                                input logic [23:0] addr, input logic [31:0] data, input logic [31:0] rdata);
        exp_t e;
        e.lat = lat; e.cs = cs; e.pre = pre; e.strb = strb; e.we = we;
        e.doe = doe; e.gap = gap; e.addr = addr; e.data = data; e.rdata = rdata;
        return e;
    endfunction

    task automatic issue(input int k, input logic wr, input logic [23:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input logic hold, input logic push, input exp_t e);
        int b;
        d_wr[k] = wr; d_addr[k] = addr; d_wdata[k] = wdata; d_be[k] = be;
        d_valid[k] = 1'b1;
        if (push) exp_q[k].push_back(e);
        b = 0;
        while (!(m_ready[k] && rst_n)) begin
            @(negedge clk);
            b++;
            if (b > 200) begin
                $display("FAIL accept_timeout dut%0d: req_ready never 1 required within 200 cycles", k);
                $fatal(1, "request not accepted");
            end
        end
        @(posedge clk);
        #1;
        if (!hold) d_valid[k] = 1'b0;
    endtask

    task automatic drain(input int k);
        int b;
        b = 0;
        while (exp_q[k].size() != 0) begin
            @(negedge clk);
            b++;
            if (b > 300) begin
                $display("FAIL drain_timeout dut%0d: %0d responses outstanding required 0", k, exp_q[k].size());
                $fatal(1, "responses outstanding");
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t nx;
        nx = mk(0, 0, 0, 0, 4'hF, 0, -1, 24'h0, 32'h0, 32'h0);
        for (int k = 0; k < 2; k++) begin
            d_valid[k] = 1'b0; d_wr[k] = 1'b0; d_addr[k] = 24'h0;
            d_wdata[k] = 32'h0; d_be[k] = 4'h0; slave_val[k] = 32'h0;
        end
        // Release reset between a posedge and the following negedge; the first request
        // is already pending and must be taken on the very next rising edge.
        #17 rst_n = 1'b1;

        issue(0, 1'b1, 24'h000123, 32'hA5A5_1234, 4'hF, 1'b0, 1'b1,
              mk(6, 5, 1, 3, 4'h0, 5, -1, 24'h000123, 32'hA5A5_1234, 32'h0));
        drain(0);

        slave_val[0] = 32'hDEAD_BEEF;
        issue(0, 1'b0, 24'h000456, 32'h0, 4'hF, 1'b0, 1'b1,
              mk(7, 5, 1, 3, 4'hF, 0, -1, 24'h000456, 32'h0, 32'hDEAD_BEEF));
        drain(0);

        issue(0, 1'b1, 24'h000789, 32'h1122_3344, 4'b0101, 1'b0, 1'b1,
              mk(6, 5, 1, 3, 4'b1010, 5, -1, 24'h000789, 32'h1122_3344, 32'hDEAD_BEEF));
        drain(0);

        issue(0, 1'b1, 24'h000999, 32'h5555_AAAA, 4'h0, 1'b0, 1'b1,
              mk(2, 0, 0, 0, 4'hF, 0, -1, 24'h0, 32'h0, 32'hDEAD_BEEF));
        drain(0);

        // Back-to-back: second request's fields appear while the first is in flight.
        issue(0, 1'b1, 24'h0000AA, 32'hCAFE_0001, 4'hF, 1'b1, 1'b1,
              mk(6, 5, 1, 3, 4'h0, 5, -1, 24'h0000AA, 32'hCAFE_0001, 32'hDEAD_BEEF));
        issue(0, 1'b1, 24'h0000BB, 32'hCAFE_0002, 4'h3, 1'b0, 1'b1,
              mk(6, 5, 1, 3, 4'hC, 5, 1, 24'h0000BB, 32'hCAFE_0002, 32'hDEAD_BEEF));
        drain(0);

        slave_val[1] = 32'h0BAD_F00D;
        issue(1, 1'b0, 24'hABCDEF, 32'h0, 4'hF, 1'b0, 1'b1,
              mk(10, 8, 1, 5, 4'hF, 0, -1, 24'hABCDEF, 32'h0, 32'h0BAD_F00D));
        drain(1);

        // Abort a write in its second strobe cycle; no completion may follow.
        issue(0, 1'b1, 24'h000777, 32'h7777_7777, 4'hF, 1'b0, 1'b0, nx);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #5 rst_n = 1'b1;
        @(posedge clk);
        #1;

        slave_val[0] = 32'h1234_5678;
        issue(0, 1'b0, 24'h000321, 32'h0, 4'hF, 1'b0, 1'b1,
              mk(7, 5, 1, 3, 4'hF, 0, -1, 24'h000321, 32'h0, 32'h1234_5678));
        drain(0);

        issue(0, 1'b1, 24'h000654, 32'h0000_0000, 4'hF, 1'b0, 1'b1,
              mk(6, 5, 1, 3, 4'h0, 5, -1, 24'h000654, 32'h0, 32'h1234_5678));
        drain(0);

        repeat (5) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000 required finished");
        $fatal(1, "watchdog");
    end
endmodule
